// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU by shift-add, DIV/DIVU by restoring shift-subtract, one bit per
// cycle. busy_o stalls the pipeline during RUN and FIX; done_o pulses once
// HI/LO hold the result. MTHI/MTLO writes are accepted only while idle.
// Optional build macro MDU_EARLY_OUT_EN: multiplies leave RUN as soon as the
// remaining multiplier bits are all zero (divide latency unchanged).
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]        state_q;
  logic              is_div_q;
  logic              neg_res_q;
  logic              neg_dvd_q;
  logic              div0_q;
  logic [CNT_W-1:0]  cnt_q;
  // Multiply: running product. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] prod_q;
  // Multiplicand shifted left one place per iteration (multiply only).
  logic [2*XLEN-1:0] mcand_q;
  // Multiply: multiplier shifted right per iteration. Divide: divisor.
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              done_q;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_tmp;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;
  logic              mul_early;

  // Operand magnitudes and signs captured at launch (signed ops only)
  always_comb begin
    a_neg = ~op_i[0] & a_i[XLEN-1];
    b_neg = ~op_i[0] & b_i[XLEN-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // One radix-2 iteration for each operation class
  always_comb begin
    mul_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    div_tmp  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge   = div_tmp >= {1'b0, mplier_q};
    div_rem  = div_ge ? XLEN'(div_tmp - {1'b0, mplier_q}) : div_tmp[XLEN-1:0];
    div_next = {div_rem, prod_q[XLEN-2:0], div_ge};
  end

`ifdef MDU_EARLY_OUT_EN
  // Bits above the one consumed this cycle are all zero: product is complete
  assign mul_early = ~is_div_q & (mplier_q[XLEN-1:1] == '0);
`else
  assign mul_early = 1'b0;
`endif

  // Sign correction and HI/LO placement applied in FIX
  always_comb begin
    mul_res = neg_res_q ? -prod_q : prod_q;
    if (is_div_q) begin
      fix_lo = div0_q ? '1 :
               (neg_res_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0]);
      // With a zero divisor every quotient bit is set and the remainder is
      // the dividend magnitude, so restoring its sign yields a_i for HI.
      fix_hi = neg_dvd_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    end else begin
      fix_lo = mul_res[XLEN-1:0];
      fix_hi = mul_res[2*XLEN-1:XLEN];
    end
  end

  // Control FSM, datapath registers and architectural HI/LO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      div0_q    <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i && !flush_i) begin
            state_q   <= RUN;
            is_div_q  <= op_i[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_dvd_q <= a_neg;
            div0_q    <= (b_i == '0);
            cnt_q     <= CNT_W'(XLEN - 1);
            mcand_q   <= {{XLEN{1'b0}}, a_mag};
            mplier_q  <= b_mag;
            prod_q    <= op_i[1] ? {{XLEN{1'b0}}, a_mag} : '0;
          end
        end
        RUN: begin
          if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            if (is_div_q) begin
              prod_q <= div_next;
            end else begin
              prod_q   <= mul_next;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end
            if (cnt_q == '0 || mul_early) begin
              state_q <= FIX;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush_i) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == RUN) || (state_q == FIX);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Testbench for mdu_iterative (XLEN=32): directed cases plus random
// operations checked against an arithmetic reference model.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mdu_iterative #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .flush_i(flush),
    .hi_we_i(hi_we),
    .lo_we_i(lo_we),
    .wdata_i(wdata),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural MIPS-style results from plain arithmetic
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint          sa = longint'($signed(ma));
    longint          sb = longint'($signed(mb));
    longint unsigned ua = {32'd0, ma};
    longint unsigned ub = {32'd0, mb};
    longint          sp;
    longint unsigned up;
    case (mop)
      2'b00: begin sp = sa * sb; ehi = sp[63:32]; elo = sp[31:0]; end
      2'b01: begin up = ua * ub; ehi = up[63:32]; elo = up[31:0]; end
      2'b10: begin
        if (mb == 32'd0) begin elo = 32'hFFFF_FFFF; ehi = ma; end
        else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin elo = ma; ehi = 32'd0; end
        else begin sp = sa / sb; elo = sp[31:0]; sp = sa % sb; ehi = sp[31:0]; end
      end
      default: begin
        if (mb == 32'd0) begin elo = 32'hFFFF_FFFF; ehi = ma; end
        else begin up = ua / ub; elo = up[31:0]; up = ua % ub; ehi = up[31:0]; end
      end
    endcase
  endfunction

  // Expected number of cycles busy_o stays high for one operation
  function automatic int exp_busy(input logic [1:0] mop, input logic [31:0] mb);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] mag;
    int          r;
    if (!mop[1]) begin
      mag = (mop == 2'b00 && mb[31]) ? -mb : mb;
      r = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) r = i + 1;
      return r + 1;
    end
`endif
    return 33;
  endfunction

  // Launch one op, optionally with LO write at launch and a poke while busy
  task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] ma,
                        input logic [31:0] mb, input bit wr_at_start, input bit poke);
    logic [31:0] ehi, elo, hi_before;
    int          busy_n;
    bit          seen;
    model(mop, ma, mb, ehi, elo);
    @(negedge clk);
    start = 1'b1; op = mop; a = ma; b = mb;
    lo_we = wr_at_start; wdata = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    if (wr_at_start) check({tag, "_lo_wr_at_start"}, {32'd0, lo}, 64'h55);
    hi_before = hi;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) busy_n++;
      if (poke && i == 5) check({tag, "_hi_no_write_busy"}, {32'd0, hi}, {32'd0, hi_before});
      if (poke && i == 4) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0;
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy(mop, mb)));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          dones;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'h8000_0007, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("multu_5x3", 2'b01, 32'd5, 32'd3, 1'b0, 1'b0);
    run_op("mult_bzero", 2'b00, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    run_op("mult_bmin", 2'b00, 32'd3, 32'h8000_0000, 1'b0, 1'b0);
    run_op("wr_with_start", 2'b01, 32'd9, 32'd9, 1'b1, 1'b0);
    run_op("busy_ignore", 2'b10, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1);

    // Flush in RUN cycle 10: HI/LO keep their values, no done pulse
    @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_00AA;
    @(negedge clk); lo_we = 1'b0;
    check("preload_lo", {32'd0, lo}, 64'hAA);
    ra = hi;
    start = 1'b1; op = 2'b00; a = 32'd77; b = 32'd99;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy_after", {63'd0, busy}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_lo_kept", {32'd0, lo}, 64'hAA);
    check("flush_hi_kept", {32'd0, hi}, {32'd0, ra});

    // Flush and start together in IDLE: nothing starts
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {63'd0, busy}, 64'd0);

    // Reset mid-operation returns everything to zero
    hi_we = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk); hi_we = 1'b0;
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(dones), 64'd0);

    // Random operations, with occasional edge operands
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 300));
        default: ;
      endcase
      run_op("random", rop, ra, rb, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
